icache_word: RTL

Single-outstanding, direct-mapped instruction cache that answers the fetch unit's icache request/response handshake. It holds one 32-bit instruction word per line and refills misses from a backing memory port with a valid/ready handshake. It sits between the frontend (fetch) and the memory system. It supports a flush for trap, mret and redirect, and a full invalidate for fence.i.

---
 rtl/icache_word.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/icache_word.sv
// Direct-mapped, single-outstanding instruction cache holding one 32-bit word per line.
// Misses refill from a valid/ready memory port; supports flush and full invalidate.
module icache_word #(
    parameter int unsigned LINES  = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              icache_req_valid,
    input  logic [ADDR_W-1:0] fetch_address,
    output logic              icache_req_ready,
    output logic              icache_resp_valid,
    output logic [31:0]       fetch_data,
    output logic [ADDR_W-1:0] icache_resp_address,
    output logic              icache_resp_err,
    input  logic              icache_resp_ready,
    input  logic              flush_i,
    input  logic              invalidate_i,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MREQ,
        S_MWAIT,
        S_RESP
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] req_addr;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              misaligned;
    logic              hit;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES];

    logic drop, drop_nx;
    logic kill_fill, kill_fill_nx;

    logic accept_c, load_hit_c, load_err_c, load_fill_c, fill_we_c;

    assign req_idx             = req_addr[IDX_W+1:2];
    assign req_tag             = req_addr[ADDR_W-1:IDX_W+2];
    assign misaligned          = (req_addr[1:0] != 2'b00);
    assign hit                 = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign icache_resp_address = req_addr;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, handshake decode and drop/kill bookkeeping
    always_comb begin
        state_nx         = state;
        icache_req_ready = 1'b0;
        accept_c         = 1'b0;
        load_hit_c       = 1'b0;
        load_err_c       = 1'b0;
        load_fill_c      = 1'b0;
        fill_we_c        = 1'b0;
        drop_nx          = drop;
        kill_fill_nx     = kill_fill;

        case (state)
            S_IDLE: begin
                icache_req_ready = !flush_i;
                if (icache_req_valid && !flush_i) begin
                    accept_c = 1'b1;
                    state_nx = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (flush_i) begin
                    state_nx = S_IDLE;
                end else if (misaligned) begin
                    load_err_c = 1'b1;
                    state_nx   = S_RESP;
                end else if (hit) begin
                    load_hit_c = 1'b1;
                    state_nx   = S_RESP;
                end else begin
                    state_nx = S_MREQ;
                end
            end
            S_MREQ: begin
                if (mem_req_ready) begin
                    state_nx = S_MWAIT;
                    if (flush_i) begin
                        drop_nx = 1'b1;
                    end
                end else if (flush_i) begin
                    state_nx = S_IDLE;
                end
            end
            S_MWAIT: begin
                if (flush_i) begin
                    drop_nx = 1'b1;
                end
                if (mem_resp_valid) begin
                    fill_we_c = !kill_fill;
                    if (drop || flush_i) begin
                        state_nx = S_IDLE;
                    end else begin
                        load_fill_c = 1'b1;
                        state_nx    = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (flush_i || icache_resp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // A refill still in flight when invalidate lands must not repopulate the line
        if (invalidate_i && (state_nx == S_MWAIT)) begin
            kill_fill_nx = 1'b1;
        end
        if ((state == S_MWAIT) && (state_nx != S_MWAIT)) begin
            drop_nx      = 1'b0;
            kill_fill_nx = 1'b0;
        end
    end

    // Request, response and refill-request registers plus line valid bits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_addr          <= '0;
            icache_resp_valid <= 1'b0;
            fetch_data        <= '0;
            icache_resp_err   <= 1'b0;
            mem_req_valid     <= 1'b0;
            mem_req_addr      <= '0;
            drop              <= 1'b0;
            kill_fill         <= 1'b0;
            valid_q           <= '0;
        end else begin
            if (accept_c) begin
                req_addr <= fetch_address;
            end
            icache_resp_valid <= (state_nx == S_RESP);
            mem_req_valid     <= (state_nx == S_MREQ);
            if ((state == S_LOOKUP) && (state_nx == S_MREQ)) begin
                mem_req_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            end
            if (load_err_c) begin
                fetch_data      <= '0;
                icache_resp_err <= 1'b1;
            end else if (load_hit_c) begin
                fetch_data      <= data_q[req_idx];
                icache_resp_err <= 1'b0;
            end else if (load_fill_c) begin
                fetch_data      <= mem_resp_data;
                icache_resp_err <= 1'b0;
            end
            drop      <= drop_nx;
            kill_fill <= kill_fill_nx;
            if (invalidate_i) begin
                valid_q <= '0;
            end else if (fill_we_c) begin
                valid_q[req_idx] <= 1'b1;
            end
        end
    end

    // Line tag/data storage; qualified by the valid bits so no reset needed
    always_ff @(posedge clk) begin
        if (fill_we_c) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= mem_resp_data;
        end
    end

endmodule
